// File: rtl/gan_frame_bit_tx.sv
// Serializes a captured frame of signed samples into a valid/ready bit stream.
// Each bit is 1 when its sample is strictly greater than THRESHOLD (signed compare).
module gan_frame_bit_tx #(
    parameter int                          PIXEL_COUNT = 784,
    parameter int                          SAMPLE_W    = 16,
    parameter logic signed [SAMPLE_W-1:0]  THRESHOLD   = 16'sd0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SAMPLE_W*PIXEL_COUNT-1:0] frame_flat,
    input  logic                            frame_valid,
    output logic                            pixel_bit,
    output logic                            pixel_bit_valid,
    input  logic                            pixel_bit_ready,
    output logic                            pixel_last,
    output logic [9:0]                      pixel_index,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            frame_dropped
);

    localparam int              IDX_W    = 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  index_q, index_d;
    logic [SAMPLE_W*PIXEL_COUNT-1:0]   frame_q, frame_d;
    logic                              dropped_q, dropped_d;
    logic signed [SAMPLE_W-1:0]        sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            frame_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            frame_q   <= frame_d;
            dropped_q <= dropped_d;
        end
    end

    // DONE accepts a new load just like IDLE, so back-to-back frames lose no strobe.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        frame_d   = frame_q;
        dropped_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (frame_valid) begin
                    frame_d = frame_flat;
                    index_d = '0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                dropped_d = frame_valid;
                if (pixel_bit_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sample          = frame_q[index_q*SAMPLE_W +: SAMPLE_W];
        pixel_bit_valid = (state_q == ST_SEND);
        busy            = (state_q == ST_SEND);
        pixel_bit       = pixel_bit_valid && (sample > THRESHOLD);
        pixel_last      = pixel_bit_valid && (index_q == LAST_IDX);
        pixel_index     = index_q;
        frame_done      = (state_q == ST_DONE);
        frame_dropped   = dropped_q;
    end

endmodule

// File: tb/tb_gan_frame_bit_tx.sv
// Self-checking bench for gan_frame_bit_tx: two instances (threshold 0 and 0x0080)
// share all inputs and are compared against a per-pixel expected-bit model.
module tb_gan_frame_bit_tx;

    localparam int PC = 784;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [SW*PC-1:0] frame_flat = '0;
    logic            frame_valid = 1'b0;
    logic            ready = 1'b0;

    logic       a_bit, a_valid, a_last, a_busy, a_done, a_drop;
    logic [9:0] a_index;
    logic       b_bit, b_valid, b_last, b_busy, b_done, b_drop;
    logic [9:0] b_index;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SW-1:0] pix[PC];
    logic          ref_a[PC];
    logic          ref_b[PC];

    typedef struct {
        logic [SW-1:0] sample;
        logic          exp_a;
        logic          exp_b;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    gan_frame_bit_tx dut_a (
        .clk(clk), .rst(rst), .frame_flat(frame_flat), .frame_valid(frame_valid),
        .pixel_bit(a_bit), .pixel_bit_valid(a_valid), .pixel_bit_ready(ready),
        .pixel_last(a_last), .pixel_index(a_index), .busy(a_busy),
        .frame_done(a_done), .frame_dropped(a_drop)
    );

    gan_frame_bit_tx #(.THRESHOLD(16'sh0080)) dut_b (
        .clk(clk), .rst(rst), .frame_flat(frame_flat), .frame_valid(frame_valid),
        .pixel_bit(b_bit), .pixel_bit_valid(b_valid), .pixel_bit_ready(ready),
        .pixel_last(b_last), .pixel_index(b_index), .busy(b_busy),
        .frame_done(b_done), .frame_dropped(b_drop)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_a_bit"},   a_bit, 0);
        checkOutput({tag, "_a_valid"}, a_valid, 0);
        checkOutput({tag, "_a_last"},  a_last, 0);
        checkOutput({tag, "_a_index"}, a_index, 0);
        checkOutput({tag, "_a_busy"},  a_busy, 0);
        checkOutput({tag, "_a_done"},  a_done, 0);
        checkOutput({tag, "_a_drop"},  a_drop, 0);
        checkOutput({tag, "_b_bit"},   b_bit, 0);
        checkOutput({tag, "_b_valid"}, b_valid, 0);
        checkOutput({tag, "_b_index"}, b_index, 0);
        checkOutput({tag, "_b_done"},  b_done, 0);
    endtask

    task automatic randomFrame();
        for (int i = 0; i < PC; i++) begin
            case ($urandom_range(0, 5))
                0:       pix[i] = 16'h0080;
                1:       pix[i] = 16'h0000;
                2:       pix[i] = 16'h8000;
                default: pix[i] = 16'($urandom);
            endcase
        end
    endtask

    // Entered and left on a negedge; snapshots the expected bits at load time.
    task automatic applyStimulus();
        checkOutput("idle_valid_before_load", a_valid, 0);
        for (int i = 0; i < PC; i++) begin
            frame_flat[i*SW +: SW] = pix[i];
            ref_a[i] = int'($signed(pix[i])) > 0;
            ref_b[i] = int'($signed(pix[i])) > 128;
        end
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic checkPresent(input int k);
        checkOutput("a_valid", a_valid, 1);
        checkOutput("a_busy",  a_busy, 1);
        checkOutput("a_index", a_index, k);
        checkOutput("a_bit",   a_bit, ref_a[k]);
        checkOutput("a_last",  a_last, (k == PC - 1));
        checkOutput("b_index", b_index, k);
        checkOutput("b_bit",   b_bit, ref_b[k]);
        checkOutput("b_last",  b_last, (k == PC - 1));
    endtask

    // mode 0: ready high; 1: ready 0,1,0,1...; 2: random ready.
    task automatic streamFrame(input int mode, input int start, input int stop,
                               input int drop_at, output int cycles);
        int  count;
        bit  fv_prev;
        bit  drop_done;
        bit  xfer;
        count     = start;
        fv_prev   = 1'b0;
        drop_done = 1'b0;
        cycles    = 0;
        while (count < stop && cycles < 4 * PC) begin
            checkPresent(count);
            checkOutput("a_dropped", a_drop, fv_prev);
            checkOutput("b_dropped", b_drop, fv_prev);
            checkOutput("a_done_midframe", a_done, 0);
            fv_prev     = 1'b0;
            frame_valid = 1'b0;
            if (count == drop_at && !drop_done) begin
                frame_valid = 1'b1;
                fv_prev     = 1'b1;
                drop_done   = 1'b1;
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cycles % 2 == 1);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            xfer = ready && a_valid;
            @(negedge clk);
            cycles++;
            if (xfer) count++;
        end
        frame_valid = 1'b0;
        if (count < stop) checkOutput("stream_timeout", count, stop);
        if (stop == PC) begin
            checkOutput("end_a_valid", a_valid, 0);
            checkOutput("end_a_busy",  a_busy, 0);
            checkOutput("end_a_last",  a_last, 0);
            checkOutput("end_a_done",  a_done, 1);
            checkOutput("end_b_done",  b_done, 1);
            checkOutput("end_a_dropped", a_drop, fv_prev);
            @(negedge clk);
            checkOutput("after_a_done", a_done, 0);
            checkOutput("after_a_valid", a_valid, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        vecs[0] = '{16'h0080, 1'b1, 1'b0};
        vecs[1] = '{16'h0081, 1'b1, 1'b1};
        vecs[2] = '{16'h8000, 1'b0, 1'b0};
        vecs[3] = '{16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{16'h0001, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h007F, 1'b1, 1'b0};

        rst = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkAllZero("reset");

        $display("[TB] ramp frame, ready high");
        for (int i = 0; i < PC; i++) pix[i] = 16'(i);
        applyStimulus();
        streamFrame(0, 0, PC, -1, cyc);
        checkOutput("ramp_cycles", cyc, PC);

        $display("[TB] alternating frame, ready toggling");
        for (int i = 0; i < PC; i++) pix[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
        applyStimulus();
        streamFrame(1, 0, PC, -1, cyc);
        checkOutput("toggle_cycles", cyc, 2 * PC);

        $display("[TB] threshold vector table");
        randomFrame();
        for (int i = 0; i < 8; i++) pix[i] = vecs[i].sample;
        applyStimulus();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("vec_a_bit", a_bit, vecs[i].exp_a);
            checkOutput("vec_b_bit", b_bit, vecs[i].exp_b);
            checkOutput("vec_index", a_index, i);
            @(negedge clk);
        end
        streamFrame(0, 8, PC, -1, cyc);

        $display("[TB] reload strobe during send");
        randomFrame();
        applyStimulus();
        streamFrame(0, 0, PC, 100, cyc);
        checkOutput("drop_cycles", cyc, PC);

        $display("[TB] upstream frame change after capture");
        randomFrame();
        applyStimulus();
        for (int i = 0; i < PC; i++) frame_flat[i*SW +: SW] = 16'h7FFF;
        streamFrame(2, 0, PC, -1, cyc);

        $display("[TB] reset mid-frame");
        randomFrame();
        applyStimulus();
        streamFrame(0, 0, 400, -1, cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("midreset");
        @(negedge clk);
        checkOutput("midreset_no_done", a_done, 0);
        checkOutput("midreset_idle_valid", a_valid, 0);
        randomFrame();
        applyStimulus();
        streamFrame(2, 0, PC, -1, cyc);

        $display("[TB] random frames, random ready");
        for (int f = 0; f < 2; f++) begin
            randomFrame();
            applyStimulus();
            streamFrame(2, 0, PC, $urandom_range(0, PC - 2), cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
